// File: rtl/lif_integrate_ctrl_pkg.sv
// Shared types, default parameters and saturation helper for the LIF integrate controller.
package lif_pkg;

  localparam int DEF_WIDTH      = 12;
  localparam int DEF_LEAK_SHIFT = 4;
  localparam int DEF_V_TH       = 400;
  localparam int DEF_T_REF      = 4;
  localparam int DEF_REF_W      = 3;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIRE,
    REFRACT
  } state_t;

  // Clamp a sign-extended wide value into the signed range of a w-bit result.
  function automatic logic signed [31:0] saturate(input logic signed [31:0] x,
                                                  input int unsigned w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 32'd1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (x > hi) return hi;
    else if (x < lo) return lo;
    else return x;
  endfunction

endpackage

// File: rtl/lif_integrate_ctrl_if.sv
// Sample handshake and membrane-register control bundle of the LIF integrate controller.
interface lif_integrate_ctrl_if #(
  parameter int WIDTH = lif_pkg::DEF_WIDTH
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_current;
  logic signed [WIDTH-1:0] v_mem;
  logic signed [WIDTH-1:0] v_next;
  logic                    load;
  logic                    init;
  logic                    spike;
  logic                    refractory;

  modport master (
    output in_valid, in_current, v_mem,
    input  in_ready, v_next, load, init, spike, refractory
  );

  modport slave (
    input  in_valid, in_current, v_mem,
    output in_ready, v_next, load, init, spike, refractory
  );
endinterface

// File: rtl/lif_integrate_ctrl_leak_integrate.sv
// Leaky integration: v_mem - (v_mem >>> LEAK_SHIFT) + cur, saturated back to WIDTH bits.
module lif_leak_integrate
  import lif_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
) (
  input  logic signed [WIDTH-1:0] v_mem,
  input  logic signed [WIDTH-1:0] cur,
  output logic signed [WIDTH-1:0] sat
);

  logic signed [WIDTH+1:0] v_ext;
  logic signed [WIDTH+1:0] c_ext;
  logic signed [WIDTH+1:0] leak;
  logic signed [WIDTH+1:0] sum;

  always_comb begin
    v_ext = (WIDTH+2)'(v_mem);
    c_ext = (WIDTH+2)'(cur);
    leak  = v_ext >>> LEAK_SHIFT;
    sum   = v_ext - leak + c_ext;
    sat   = WIDTH'(saturate(32'(sum), WIDTH));
  end

endmodule

// File: rtl/lif_integrate_ctrl.sv
// LIF neuron integrate controller: sample handshake, leaky integration, threshold fire, refractory hold-off.
module lif_integrate_ctrl
  import lif_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int V_TH       = DEF_V_TH,
  parameter int T_REF      = DEF_T_REF,
  parameter int REF_W      = DEF_REF_W
) (
  input logic                clk,
  input logic                rst,
  lif_integrate_ctrl_if.slave bus
);

  localparam logic signed [WIDTH-1:0] TH = WIDTH'(V_TH);

  state_t                  state, state_n;
  logic signed [WIDTH-1:0] cur_q;
  logic signed [WIDTH-1:0] sat;
  logic [REF_W-1:0]        cnt, cnt_n;
  logic                    capture;

  lif_leak_integrate #(
    .WIDTH      (WIDTH),
    .LEAK_SHIFT (LEAK_SHIFT)
  ) u_leak (
    .v_mem (bus.v_mem),
    .cur   (cur_q),
    .sat   (sat)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cur_q <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (capture) cur_q <= bus.in_current;
    end
  end

  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    capture        = 1'b0;
    bus.in_ready   = 1'b0;
    bus.load       = 1'b0;
    bus.init       = 1'b0;
    bus.spike      = 1'b0;
    bus.refractory = 1'b0;
    bus.v_next     = '0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          capture = 1'b1;
          state_n = CALC;
        end
      end
      CALC: begin
        bus.v_next = sat;
        bus.load   = 1'b1;
        // Decide on the value being loaded; v_mem still holds the old potential.
        state_n    = (sat >= TH) ? FIRE : IDLE;
      end
      FIRE: begin
        bus.spike = 1'b1;
        bus.init  = 1'b1;
        if (T_REF > 0) begin
          state_n = REFRACT;
          cnt_n   = REF_W'(T_REF);
        end else begin
          state_n = IDLE;
        end
      end
      REFRACT: begin
        // Ready stays high so upstream drains; accepted samples are discarded.
        bus.refractory = 1'b1;
        bus.in_ready   = 1'b1;
        cnt_n          = cnt - REF_W'(1);
        if (cnt == REF_W'(1)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lif_integrate_ctrl.sv
// Randomized and directed self-checking bench for lif_integrate_ctrl against a transaction-level model.
module tb_lif_integrate_ctrl;

  localparam int WIDTH      = 12;
  localparam int LEAK_SHIFT = 4;
  localparam int V_TH       = 400;
  localparam int T_REF      = 4;
  localparam int MAXV       = 2047;
  localparam int MINV       = -2048;

  typedef struct {
    bit ready;
    bit load;
    bit init;
    bit spike;
    bit refr;
    int vn;
  } exp_t;

  logic clk;
  logic rst;

  lif_integrate_ctrl_if #(.WIDTH(WIDTH)) bus ();

  lif_integrate_ctrl #(
    .WIDTH      (WIDTH),
    .LEAK_SHIFT (LEAK_SHIFT),
    .V_TH       (V_TH),
    .T_REF      (T_REF),
    .REF_W      (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t q[$];
  exp_t head;
  exp_t idle_e;
  int   reg_v    = 0;
  int   acc_cnt  = 0;
  bit   chk_en   = 0;
  logic cur_rst;
  logic cur_valid;
  int   cur_c;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Model: an accepted sample schedules one calc cycle, then optionally fire + T_REF hold-off cycles.
  task automatic accept(input int c);
    int   s;
    exp_t e;
    s = reg_v - (reg_v >>> LEAK_SHIFT) + c;
    if (s > MAXV) s = MAXV;
    if (s < MINV) s = MINV;
    e = '{ready: 0, load: 1, init: 0, spike: 0, refr: 0, vn: s};
    q.push_back(e);
    if (s >= V_TH) begin
      e = '{ready: 0, load: 0, init: 1, spike: 1, refr: 0, vn: 0};
      q.push_back(e);
      for (int i = 0; i < T_REF; i++) begin
        e = '{ready: 1, load: 0, init: 0, spike: 0, refr: 1, vn: 0};
        q.push_back(e);
      end
    end
    acc_cnt++;
  endtask

  task automatic drive(input logic r, input logic v, input int c);
    @(negedge clk);
    rst            = r;
    bus.in_valid   = v;
    bus.in_current = WIDTH'(c);
    bus.v_mem      = WIDTH'(reg_v);
    cur_rst        = r;
    cur_valid      = v;
    cur_c          = c;
    #1;
    head = (q.size() != 0) ? q[0] : idle_e;
    if (chk_en) begin
      check("in_ready",   int'(bus.in_ready),   int'(head.ready));
      check("load",       int'(bus.load),       int'(head.load));
      check("init",       int'(bus.init),       int'(head.init));
      check("spike",      int'(bus.spike),      int'(head.spike));
      check("refractory", int'(bus.refractory), int'(head.refr));
      check("v_next",     int'(bus.v_next),     head.vn);
    end
  endtask

  task automatic tick();
    bit was_idle;
    @(posedge clk);
    // Membrane register model reacts to whatever strobes the block showed this cycle.
    if (head.load) reg_v = head.vn;
    if (head.init) reg_v = 0;
    if (!cur_rst) begin
      q.delete();
    end else begin
      was_idle = (q.size() == 0);
      if (!was_idle) void'(q.pop_front());
      if (was_idle && cur_valid) accept(cur_c);
    end
  endtask

  task automatic cyc(input logic r, input logic v, input int c);
    drive(r, v, c);
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && q.size() != 0; i++) cyc(1'b1, 1'b0, 0);
  endtask

  initial begin
    int nloads;
    int base;
    idle_e = '{ready: 1, load: 0, init: 0, spike: 0, refr: 0, vn: 0};
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_current = '0;
    bus.v_mem = '0;

    // Reset with valid asserted: nothing may be captured.
    cyc(1'b0, 1'b1, 5);
    chk_en = 1;
    cyc(1'b0, 1'b1, 5);
    drive(1'b1, 1'b0, 0);
    check("rst_ready", int'(bus.in_ready), 1);
    check("rst_load", int'(bus.load), 0);
    tick();
    drive(1'b1, 1'b0, 0);
    check("rst_nocapture", int'(bus.load), 0);
    tick();

    // Sub-threshold.
    reg_v = 160;
    cyc(1'b1, 1'b1, 50);
    drive(1'b1, 1'b0, 0);
    check("sub_vnext", int'(bus.v_next), 200);
    check("sub_load", int'(bus.load), 1);
    tick();
    drive(1'b1, 1'b0, 0);
    check("sub_load_once", int'(bus.load), 0);
    check("sub_nospike", int'(bus.spike), 0);
    tick();

    // Fire followed by refractory with samples presented.
    reg_v = 368;
    cyc(1'b1, 1'b1, 60);
    drive(1'b1, 1'b1, 60);
    check("fire_vnext", int'(bus.v_next), 405);
    tick();
    drive(1'b1, 1'b1, 7);
    check("fire_spike", int'(bus.spike), 1);
    check("fire_init", int'(bus.init), 1);
    check("fire_noload", int'(bus.load), 0);
    tick();
    for (int i = 0; i < T_REF; i++) begin
      drive(1'b1, 1'b1, 9);
      check("ref_hold", int'(bus.refractory), 1);
      check("ref_ready", int'(bus.in_ready), 1);
      check("ref_noload", int'(bus.load), 0);
      tick();
    end
    drive(1'b1, 1'b0, 0);
    check("ref_exit", int'(bus.refractory), 0);
    tick();

    // Positive and negative saturation.
    reg_v = 2000;
    cyc(1'b1, 1'b1, 2047);
    drive(1'b1, 1'b0, 0);
    check("satp_vnext", int'(bus.v_next), 2047);
    tick();
    drive(1'b1, 1'b0, 0);
    check("satp_spike", int'(bus.spike), 1);
    tick();
    drain();
    reg_v = -2000;
    cyc(1'b1, 1'b1, -2048);
    drive(1'b1, 1'b0, 0);
    check("satn_vnext", int'(bus.v_next), -2048);
    tick();
    drive(1'b1, 1'b0, 0);
    check("satn_nospike", int'(bus.spike), 0);
    tick();

    // Reset during the fire cycle.
    reg_v = 368;
    cyc(1'b1, 1'b1, 60);
    cyc(1'b1, 1'b0, 0);
    cyc(1'b0, 1'b0, 0);
    drive(1'b1, 1'b0, 0);
    check("midrst_spike", int'(bus.spike), 0);
    check("midrst_init", int'(bus.init), 0);
    check("midrst_refr", int'(bus.refractory), 0);
    check("midrst_ready", int'(bus.in_ready), 1);
    tick();

    // Back-to-back with valid held high.
    reg_v = 0;
    base = acc_cnt;
    nloads = 0;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, (acc_cnt - base) < 4, 10 * (acc_cnt - base + 1));
      if (bus.load) nloads++;
      tick();
    end
    check("b2b_loads", nloads, 4);
    check("b2b_final_v", reg_v, 96);

    // Randomized traffic, biased so the threshold is crossed regularly.
    for (int i = 0; i < 1500; i++) begin
      if (q.size() == 0 && $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) reg_v = int'($urandom_range(0, 4095)) - 2048;
        else reg_v = int'($urandom_range(300, 420));
      end
      cyc($urandom_range(0, 60) != 0, $urandom_range(0, 2) != 0,
          ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 120)) - 20
                                      : int'($urandom_range(0, 4095)) - 2048);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
